// File: rtl/mc_mips_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: FSM state type,
// opcode values, ALU operation class and datapath mux encodings.
package mc_mips_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEM_ADR = 4'd2,
        ST_MEM_RD  = 4'd3,
        ST_MEM_WB  = 4'd4,
        ST_MEM_WR  = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALU_WB  = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_ADDI_EX = 4'd9,
        ST_ADDI_WB = 4'd10,
        ST_JUMP    = 4'd11,
        ST_TRAP    = 4'd12,
        ST_HALT    = 4'd13
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Must stay identical to the encoding the ALU-control decoder consumes.
    localparam logic [1:0] ALU_OP_LW_SW  = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

    localparam logic [1:0] ALU_SRC_B_REG      = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM      = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
        logic       instr_done;
    } mc_ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Free-running cycle and retired-instruction counters for the main control;
// only instantiated when MC_PERF_CNT_EN is defined.
module mc_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        halted,
    input  logic        instr_done,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    logic [1:0]       inc;
    logic [1:0][31:0] cnt_reg;
    logic [1:0][31:0] cnt_next;

    // Slot 0 counts active (non-halted) cycles, slot 1 retired instructions.
    assign inc = {instr_done, !halted};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            assign cnt_next[gi] = inc[gi] ? cnt_reg[gi] + 32'd1 : cnt_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cycle_cnt = cnt_reg[0];
    assign instr_cnt = cnt_reg[1];

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM of the multi-cycle MIPS core (fetch/decode/execute/memory/writeback).
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module mc_main_control
    import mc_mips_pkg::*;
#(
    parameter int RESET_STATE_HALT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic       undefined_instr,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       halted,
    output logic       instr_done
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam mc_state_e RESET_STATE = (RESET_STATE_HALT != 0) ? ST_HALT : ST_FETCH;

    mc_state_e state_reg;
    mc_state_e state_next;
    mc_ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_TRAP;
        case (state_reg)
            ST_FETCH:   state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = ST_MEM_ADR;
                    OP_RTYPE:     state_next = ST_EXECUTE;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_ADDI:      state_next = ST_ADDI_EX;
                    OP_J:         state_next = ST_JUMP;
                    default:      state_next = ST_TRAP;
                endcase
            end
            ST_MEM_ADR: begin
                if (!is_mem_op(opcode)) begin
                    state_next = ST_TRAP;
                end else if (opcode == OP_LW) begin
                    state_next = ST_MEM_RD;
                end else begin
                    state_next = ST_MEM_WR;
                end
            end
            ST_MEM_RD:  state_next = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:  state_next = ST_FETCH;
            ST_MEM_WR:  state_next = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_EXECUTE: state_next = undefined_instr ? ST_TRAP : ST_ALU_WB;
            ST_ALU_WB:  state_next = ST_FETCH;
            ST_BRANCH:  state_next = ST_FETCH;
            ST_ADDI_EX: state_next = ST_ADDI_WB;
            ST_ADDI_WB: state_next = ST_FETCH;
            ST_JUMP:    state_next = ST_FETCH;
            ST_TRAP:    state_next = ST_TRAP;
            ST_HALT:    state_next = start ? ST_FETCH : ST_HALT;
            default:    state_next = ST_TRAP;
        endcase
    end

    // Outputs are forced to zero while rst is high so an access in flight never
    // produces a strobe in the reset cycle.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            case (state_reg)
                ST_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = ALU_SRC_B_FOUR;
                    ctrl.alu_op    = ALU_OP_LW_SW;
                    ctrl.pc_source = PC_SRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    ctrl.alu_src_b = ALU_SRC_B_IMM_SHL2;
                    ctrl.alu_op    = ALU_OP_LW_SW;
                end
                ST_MEM_ADR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALU_SRC_B_IMM;
                    ctrl.alu_op    = ALU_OP_LW_SW;
                end
                ST_MEM_RD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                ST_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                ST_MEM_WR: begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.i_or_d     = 1'b1;
                    ctrl.instr_done = mem_ready;
                end
                ST_EXECUTE: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALU_SRC_B_REG;
                    ctrl.alu_op    = ALU_OP_RTYPE;
                end
                ST_ALU_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = ALU_SRC_B_REG;
                    ctrl.alu_op        = ALU_OP_BRANCH;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PC_SRC_ALU_OUT;
                    ctrl.instr_done    = 1'b1;
                end
                ST_ADDI_EX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALU_SRC_B_IMM;
                    ctrl.alu_op    = ALU_OP_LW_SW;
                end
                ST_ADDI_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                ST_JUMP: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PC_SRC_JUMP;
                    ctrl.instr_done = 1'b1;
                end
                ST_TRAP, ST_HALT: begin
                    ctrl.halted = 1'b1;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign halted        = ctrl.halted;
    assign instr_done    = ctrl.instr_done;

`ifdef MC_PERF_CNT_EN
    mc_perf_counters u_perf (
        .clk        (clk),
        .rst        (rst),
        .halted     (halted),
        .instr_done (instr_done),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );
`endif

endmodule
